equiv_checker: RTL and testbench

- Synthesizable self-checking equivalence engine for two N_IN-input, N_OUT-output implementations of one function, e.g. a gate-level and a behavioural version.
- Drives one exhaustive stimulus bus into both external copies and compares their outputs on every vector.
- Reports pass/fail, the first failing vector and a saturating mismatch count.
- Generalises the fixed 4-input, 1-output sweep in width, output count, settle time and stop mode.

---
 rtl/equiv_pkg.sv | 15 +
 rtl/equiv_checker_sat_counter.sv | 21 ++
 rtl/equiv_checker.sv | 119 +++++++++++
 tb/tb_equiv_checker.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/equiv_pkg.sv
// Shared types and constant helpers for the exhaustive equivalence checker.
package equiv_pkg;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  // All-ones stimulus value that ends a sweep of an n-bit input space.
  function automatic int unsigned last_vec(input int unsigned n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  function automatic int unsigned settle_width(input int unsigned settle);
    return $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/equiv_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      value <= '0;
    else if (clear)
      value <= '0;
    else if (inc && (value != '1))
      value <= value + WIDTH'(1);
  end

endmodule

// File: rtl/equiv_checker.sv
// Exhaustive equivalence checker: sweeps every input vector into two external
// copies of a function and records pass/fail, first failure and mismatch count.
module equiv_checker
  import equiv_pkg::*;
#(
  parameter int unsigned N_IN         = 4,
  parameter int unsigned N_OUT        = 1,
  parameter int unsigned SETTLE       = 1,
  parameter int unsigned CNT_W        = 8,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  stim,
  input  logic [N_OUT-1:0] F_ref,
  input  logic [N_OUT-1:0] F_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN-1:0]  fail_vec,
  output logic [N_OUT-1:0] fail_ref,
  output logic [N_OUT-1:0] fail_dut,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned       SETTLE_W    = settle_width(SETTLE);
  localparam logic [N_IN-1:0]   LAST        = N_IN'(last_vec(N_IN));
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

  state_t              state, state_next;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                first_seen;
  logic                mismatch;
  logic                load, step, capture;

  // Case inequality so X/Z on either copy is flagged in simulation.
  assign mismatch = (F_ref !== F_dut);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = APPLY;
        end
      end
      APPLY: begin
        if (settle_cnt == '0)
          state_next = CHECK;
      end
      CHECK: begin
        capture = mismatch && !first_seen;
        if ((stim == LAST) || (mismatch && STOP_ON_FAIL))
          state_next = DONE;
        else begin
          step       = 1'b1;
          state_next = APPLY;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim       <= '0;
      settle_cnt <= '0;
      first_seen <= 1'b0;
      fail_vec   <= '0;
      fail_ref   <= '0;
      fail_dut   <= '0;
    end else if (load) begin
      stim       <= '0;
      settle_cnt <= SETTLE_LOAD;
      first_seen <= 1'b0;
      fail_vec   <= '0;
      fail_ref   <= '0;
      fail_dut   <= '0;
    end else begin
      if ((state == APPLY) && (settle_cnt != '0))
        settle_cnt <= settle_cnt - SETTLE_W'(1);
      if (step) begin
        stim       <= stim + N_IN'(1);
        settle_cnt <= SETTLE_LOAD;
      end
      if (capture) begin
        first_seen <= 1'b1;
        fail_vec   <= stim;
        fail_ref   <= F_ref;
        fail_dut   <= F_dut;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (load),
    .inc   ((state == CHECK) && mismatch),
    .value (err_cnt)
  );

  assign busy = (state == APPLY) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_equiv_checker.sv
// Directed bench: three checker instances (plain, stop-on-fail, 2-bit counter)
// driven against a reference function F = A&B | C^D.
module tb_equiv_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic logic fref(input logic [3:0] s);
    return (s[0] & s[1]) | (s[2] ^ s[3]);
  endfunction

  // Main instance
  logic       start_m = 1'b0, mode_m = 1'b0;
  logic [3:0] stim_m, fvec_m;
  logic       fr_m, fd_m, busy_m, done_m, pass_m, cref_m, cdut_m;
  logic [7:0] err_m;
  assign fr_m = fref(stim_m);
  assign fd_m = (mode_m && stim_m == 4'hB) ? ~fr_m : fr_m;

  equiv_checker #(.N_IN(4), .N_OUT(1), .SETTLE(1), .CNT_W(8), .STOP_ON_FAIL(1'b0)) u_main (
    .clk(clk), .rst_n(rst_n), .start(start_m), .stim(stim_m), .F_ref(fr_m), .F_dut(fd_m),
    .busy(busy_m), .done(done_m), .pass(pass_m), .fail_vec(fvec_m), .fail_ref(cref_m),
    .fail_dut(cdut_m), .err_cnt(err_m));

  // Stop-on-fail instance, mismatches at 3 and 9
  logic       start_s = 1'b0;
  logic [3:0] stim_s, fvec_s;
  logic       fr_s, fd_s, busy_s, done_s, pass_s, cref_s, cdut_s;
  logic [7:0] err_s;
  assign fr_s = fref(stim_s);
  assign fd_s = (stim_s == 4'd3 || stim_s == 4'd9) ? ~fr_s : fr_s;

  equiv_checker #(.N_IN(4), .N_OUT(1), .SETTLE(1), .CNT_W(8), .STOP_ON_FAIL(1'b1)) u_stop (
    .clk(clk), .rst_n(rst_n), .start(start_s), .stim(stim_s), .F_ref(fr_s), .F_dut(fd_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .fail_vec(fvec_s), .fail_ref(cref_s),
    .fail_dut(cdut_s), .err_cnt(err_s));

  // Saturation instance, every vector mismatches
  logic       start_t = 1'b0;
  logic [3:0] stim_t, fvec_t;
  logic       fr_t, fd_t, busy_t, done_t, pass_t, cref_t, cdut_t;
  logic [1:0] err_t;
  assign fr_t = fref(stim_t);
  assign fd_t = ~fr_t;

  equiv_checker #(.N_IN(4), .N_OUT(1), .SETTLE(1), .CNT_W(2), .STOP_ON_FAIL(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_t), .stim(stim_t), .F_ref(fr_t), .F_dut(fd_t),
    .busy(busy_t), .done(done_t), .pass(pass_t), .fail_vec(fvec_t), .fail_ref(cref_t),
    .fail_dut(cdut_t), .err_cnt(err_t));

  // Returns with time at 1 unit after the edge that sampled start.
  task automatic pulse(input int which);
    @(posedge clk); #1;
    case (which)
      0: start_m = 1'b1;
      1: start_s = 1'b1;
      default: start_t = 1'b1;
    endcase
    @(posedge clk); #1;
    start_m = 1'b0; start_s = 1'b0; start_t = 1'b0;
  endtask

  task automatic wait_done(input int which, input int limit, output int n);
    logic d;
    n = 0;
    d = (which == 0) ? done_m : (which == 1) ? done_s : done_t;
    while (!d && n < limit) begin
      @(posedge clk); #1;
      n++;
      d = (which == 0) ? done_m : (which == 1) ? done_s : done_t;
    end
    checks++;
    if (!d) begin
      failures++;
      $display("FAIL timeout_done inst=%0d waited=%0d limit=%0d", which, n, limit);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_m = 1'b1; start_s = 1'b1; start_t = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({stim_m, busy_m, done_m, pass_m, fvec_m, cref_m, cdut_m, err_m} !== '0) begin
      failures++;
      $display("FAIL reset_main got=%0h exp=0",
               {stim_m, busy_m, done_m, pass_m, fvec_m, cref_m, cdut_m, err_m});
    end
    checks++;
    if ({busy_s, done_s, err_s, busy_t, done_t, err_t} !== '0) begin
      failures++;
      $display("FAIL reset_others got=%0h exp=0", {busy_s, done_s, err_s, busy_t, done_t, err_t});
    end
    start_m = 1'b0; start_s = 1'b0; start_t = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({stim_m, busy_m, done_m, pass_m, err_m} !== '0) begin
      failures++;
      $display("FAIL post_reset_idle got=%0h exp=0", {stim_m, busy_m, done_m, pass_m, err_m});
    end
  endtask

  task automatic test_clean_sweep;
    int bad_k;
    bad_k = -1;
    mode_m = 1'b0;
    pulse(0);
    for (int k = 0; k < 16; k++) begin
      if ((stim_m !== 4'(k) || busy_m !== 1'b1) && bad_k < 0) bad_k = k;
      if (k == 5) start_m = 1'b1;
      @(posedge clk); #1;
      start_m = 1'b0;
      if ((stim_m !== 4'(k) || busy_m !== 1'b1) && bad_k < 0) bad_k = k;
      @(posedge clk); #1;
    end
    checks++;
    if (bad_k != -1) begin
      failures++;
      $display("FAIL sweep_sequence first_bad_vector=%0d exp=none", bad_k);
    end
    checks++;
    if ({done_m, busy_m} !== 2'b10) begin
      failures++;
      $display("FAIL done_at_32 got done=%0b busy=%0b exp done=1 busy=0", done_m, busy_m);
    end
    checks++;
    if ({pass_m, err_m} !== {1'b1, 8'd0}) begin
      failures++;
      $display("FAIL clean_result got pass=%0b err=%0d exp pass=1 err=0", pass_m, err_m);
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({done_m, stim_m} !== {1'b1, 4'hF}) begin
      failures++;
      $display("FAIL done_hold got done=%0b stim=%0h exp done=1 stim=f", done_m, stim_m);
    end
  endtask

  task automatic test_mismatch_at_b;
    int n;
    mode_m = 1'b1;
    pulse(0);
    wait_done(0, 100, n);
    checks++;
    if ({err_m, fvec_m, cref_m, cdut_m, pass_m} !== {8'd1, 4'hB, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mismatch_b got err=%0d vec=%0h ref=%0b dut=%0b pass=%0b exp 1 b 1 0 0",
               err_m, fvec_m, cref_m, cdut_m, pass_m);
    end
    checks++;
    if (stim_m !== 4'hF) begin
      failures++;
      $display("FAIL mismatch_b_full_sweep got stim=%0h exp=f", stim_m);
    end
  endtask

  task automatic test_restart_clean;
    int n;
    mode_m = 1'b0;
    pulse(0);
    checks++;
    if ({busy_m, err_m, fvec_m, cref_m, stim_m} !== {1'b1, 8'd0, 4'h0, 1'b0, 4'h0}) begin
      failures++;
      $display("FAIL restart_clear got busy=%0b err=%0d vec=%0h ref=%0b stim=%0h exp 1 0 0 0 0",
               busy_m, err_m, fvec_m, cref_m, stim_m);
    end
    wait_done(0, 100, n);
    checks++;
    if ({pass_m, err_m} !== {1'b1, 8'd0}) begin
      failures++;
      $display("FAIL restart_pass got pass=%0b err=%0d exp pass=1 err=0", pass_m, err_m);
    end
  endtask

  task automatic test_stop_on_fail;
    int n;
    pulse(1);
    wait_done(1, 100, n);
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL stop_latency got=%0d exp=8", n);
    end
    checks++;
    if ({stim_s, fvec_s, err_s, cref_s, cdut_s, pass_s} !== {4'd3, 4'd3, 8'd1, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL stop_result got stim=%0h vec=%0h err=%0d ref=%0b dut=%0b pass=%0b exp 3 3 1 1 0 0",
               stim_s, fvec_s, err_s, cref_s, cdut_s, pass_s);
    end
  endtask

  task automatic test_saturation;
    int n;
    pulse(2);
    wait_done(2, 100, n);
    checks++;
    if (n != 32) begin
      failures++;
      $display("FAIL sat_latency got=%0d exp=32", n);
    end
    checks++;
    if ({err_t, fvec_t, cref_t, cdut_t, pass_t} !== {2'd3, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL saturation got err=%0d vec=%0h ref=%0b dut=%0b pass=%0b exp 3 0 0 1 0",
               err_t, fvec_t, cref_t, cdut_t, pass_t);
    end
  endtask

  task automatic test_reset_mid_sweep;
    int n;
    mode_m = 1'b0;
    pulse(0);
    n = 0;
    while (stim_m !== 4'd7 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (stim_m !== 4'd7) begin
      failures++;
      $display("FAIL reach_stim7 got=%0h exp=7", stim_m);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({stim_m, busy_m, done_m, pass_m, fvec_m, cref_m, cdut_m, err_m} !== '0) begin
      failures++;
      $display("FAIL mid_sweep_reset got=%0h exp=0",
               {stim_m, busy_m, done_m, pass_m, fvec_m, cref_m, cdut_m, err_m});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({busy_m, done_m, stim_m} !== '0) begin
      failures++;
      $display("FAIL after_mid_reset_idle got=%0h exp=0", {busy_m, done_m, stim_m});
    end
  endtask

  initial begin
    test_reset;
    test_clean_sweep;
    test_mismatch_at_b;
    test_restart_clean;
    test_stop_on_fail;
    test_saturation;
    test_reset_mid_sweep;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
